// File: rtl/mux_select_arbiter.sv
// rtl/mux_select_arbiter.sv - round-robin select sequencer and capture port for a 4:1 mux
module mux_select_arbiter #(
    parameter int unsigned SETTLE = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] req,
    input  logic       mux_out,
    input  logic       ack,
    output logic       addr0,
    output logic       addr1,
    output logic [3:0] grant,
    output logic       valid,
    output logic       data
);

    typedef enum logic [1:0] {IDLE, SELECT, HOLD} state_t;

    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE - 1);

    state_t     state_q, state_d;
    logic [1:0] addr_q, addr_d;
    logic [3:0] grant_q, grant_d;
    logic       valid_q, valid_d;
    logic       data_q, data_d;
    logic [3:0] cnt_q, cnt_d;
    logic [1:0] ptr_q, ptr_d;

    logic       win_found;
    logic [1:0] win_idx;
    logic [1:0] cand;

    // Search starts one past the last completed channel, so ptr itself is tried last.
    always_comb begin
        win_found = 1'b0;
        win_idx   = ptr_q;
        cand      = ptr_q;
        for (int i = 1; i <= 4; i++) begin
            cand = ptr_q + 2'(i);
            if (!win_found && req[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        grant_d = grant_q;
        valid_d = valid_q;
        data_d  = data_q;
        cnt_d   = cnt_q;
        ptr_d   = ptr_q;
        case (state_q)
            IDLE: begin
                valid_d = 1'b0;
                grant_d = 4'b0000;
                if (win_found) begin
                    addr_d  = win_idx;
                    grant_d = 4'b0001 << win_idx;
                    cnt_d   = 4'd0;
                    state_d = SELECT;
                end
            end
            SELECT: begin
                // A withdrawn request wins over a capture due on the same edge.
                if (!req[addr_q]) begin
                    grant_d = 4'b0000;
                    state_d = IDLE;
                end else if (cnt_q == SETTLE_LAST) begin
                    data_d  = mux_out;
                    valid_d = 1'b1;
                    state_d = HOLD;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            HOLD: begin
                if (ack) begin
                    valid_d = 1'b0;
                    grant_d = 4'b0000;
                    ptr_d   = addr_q;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            addr_q  <= 2'd0;
            grant_q <= 4'b0000;
            valid_q <= 1'b0;
            data_q  <= 1'b0;
            cnt_q   <= 4'd0;
            ptr_q   <= 2'd3;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            grant_q <= grant_d;
            valid_q <= valid_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
            ptr_q   <= ptr_d;
        end
    end

    assign addr0 = addr_q[0];
    assign addr1 = addr_q[1];
    assign grant = grant_q;
    assign valid = valid_q;
    assign data  = data_q;

endmodule

// File: tb/tb_mux_select_arbiter.sv
// tb/tb_mux_select_arbiter.sv - scoreboard bench for mux_select_arbiter
module tb_mux_select_arbiter;

    localparam int SETTLE = 2;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] req;
    logic       ack;
    logic [3:0] in_vec;
    logic       mux_out;
    logic       addr0, addr1, valid, data;
    logic [3:0] grant;

    typedef struct {
        logic [3:0] g;
        logic       d;
    } xfer_t;

    xfer_t exp_q[$];
    int    errors = 0;
    int    checks = 0;

    always #5 clk = ~clk;

    assign mux_out = in_vec[{addr1, addr0}];

    mux_select_arbiter #(.SETTLE(SETTLE)) dut (
        .clk    (clk),
        .reset  (reset),
        .req    (req),
        .mux_out(mux_out),
        .ack    (ack),
        .addr0  (addr0),
        .addr1  (addr1),
        .grant  (grant),
        .valid  (valid),
        .data   (data)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        req   = 4'b0000;
        ack   = 1'b0;
        step();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset  = 1'b1;
        req    = 4'b1111;
        ack    = 1'b1;
        in_vec = 4'b1111;
        step();
        step();
        checks++; if (grant !== 4'b0000) begin errors++; $display("FAIL reset_grant got=%b want=0000", grant); end
        checks++; if ({addr1, addr0} !== 2'b00) begin errors++; $display("FAIL reset_addr got=%b want=00", {addr1, addr0}); end
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b want=0", valid); end
        checks++; if (data !== 1'b0) begin errors++; $display("FAIL reset_data got=%b want=0", data); end
        reset = 1'b0;
        req   = 4'b0000;
        ack   = 1'b0;
        step();
        checks++; if (grant !== 4'b0000) begin errors++; $display("FAIL reset_idle_grant got=%b want=0000", grant); end
    endtask

    task automatic test_single_read();
        do_reset();
        in_vec = 4'b0100;
        req    = 4'b0100;
        step();
        checks++; if (grant !== 4'b0100) begin errors++; $display("FAIL single_grant got=%b want=0100", grant); end
        checks++; if ({addr1, addr0} !== 2'b10) begin errors++; $display("FAIL single_addr got=%b want=10", {addr1, addr0}); end
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL single_valid_early got=%b want=0", valid); end
        step();
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL single_valid_settle got=%b want=0", valid); end
        step();
        checks++; if (valid !== 1'b1) begin errors++; $display("FAIL single_valid got=%b want=1", valid); end
        checks++; if (data !== 1'b1) begin errors++; $display("FAIL single_data got=%b want=1", data); end
        ack = 1'b1;
        req = 4'b0000;
        step();
        ack = 1'b0;
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL single_valid_ack got=%b want=0", valid); end
        checks++; if (grant !== 4'b0000) begin errors++; $display("FAIL single_grant_ack got=%b want=0000", grant); end
    endtask

    task automatic test_fairness(input logic [3:0] pattern);
        int    cyc, last_cyc, seen;
        xfer_t e;
        do_reset();
        in_vec = pattern;
        for (int n = 0; n < 5; n++) begin
            e.g = 4'b0001 << (n % 4);
            e.d = pattern[n % 4];
            exp_q.push_back(e);
        end
        req      = 4'b1111;
        ack      = 1'b1;
        last_cyc = -1;
        seen     = 0;
        for (cyc = 0; cyc < 60 && seen < 5; cyc++) begin
            step();
            if (valid === 1'b1) begin
                e = exp_q.pop_front();
                checks++; if (grant !== e.g) begin errors++; $display("FAIL fair_grant[%0d] got=%b want=%b", seen, grant, e.g); end
                checks++; if (data !== e.d) begin errors++; $display("FAIL fair_data[%0d] got=%b want=%b", seen, data, e.d); end
                if (last_cyc >= 0) begin
                    checks++; if (cyc - last_cyc != SETTLE + 2) begin errors++; $display("FAIL fair_period[%0d] got=%0d want=%0d", seen, cyc - last_cyc, SETTLE + 2); end
                end
                last_cyc = cyc;
                seen++;
            end
        end
        checks++; if (seen != 5) begin errors++; $display("FAIL fair_timeout got=%0d transfers want=5", seen); end
        exp_q.delete();
        req = 4'b0000;
        ack = 1'b0;
    endtask

    task automatic test_abort();
        int n;
        do_reset();
        in_vec = 4'b0000;
        req    = 4'b0001;
        for (n = 0; n < 10 && valid !== 1'b1; n++) step();
        checks++; if (valid !== 1'b1) begin errors++; $display("FAIL abort_setup got valid=%b want=1", valid); end
        ack = 1'b1;
        req = 4'b0010;
        step();
        ack = 1'b0;
        step();
        checks++; if (grant !== 4'b0010) begin errors++; $display("FAIL abort_grant got=%b want=0010", grant); end
        req = 4'b0000;
        step();
        checks++; if (grant !== 4'b0000) begin errors++; $display("FAIL abort_grant_clear got=%b want=0000", grant); end
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL abort_valid got=%b want=0", valid); end
        step();
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL abort_valid_late got=%b want=0", valid); end
        req = 4'b0011;
        step();
        checks++; if (grant !== 4'b0010) begin errors++; $display("FAIL abort_regrant got=%b want=0010", grant); end
        req = 4'b0000;
        step();
    endtask

    task automatic test_hold_stability();
        do_reset();
        in_vec = 4'b0000;
        ack    = 1'b1;
        step();
        ack = 1'b0;
        checks++; if (grant !== 4'b0000 || valid !== 1'b0) begin errors++; $display("FAIL hold_idle_ack got grant=%b valid=%b want 0000/0", grant, valid); end
        req = 4'b0001;
        step();
        checks++; if (grant !== 4'b0001) begin errors++; $display("FAIL hold_first_grant got=%b want=0001", grant); end
        step();
        step();
        checks++; if (valid !== 1'b1 || data !== 1'b0) begin errors++; $display("FAIL hold_capture got valid=%b data=%b want 1/0", valid, data); end
        for (int n = 0; n < 5; n++) begin
            in_vec = ~in_vec;
            req    = 4'($urandom_range(0, 15));
            step();
            checks++;
            if (valid !== 1'b1 || data !== 1'b0 || grant !== 4'b0001 || {addr1, addr0} !== 2'b00) begin
                errors++;
                $display("FAIL hold_frozen[%0d] got valid=%b data=%b grant=%b addr=%b want 1/0/0001/00", n, valid, data, grant, {addr1, addr0});
            end
        end
        ack = 1'b1;
        req = 4'b0000;
        step();
        ack = 1'b0;
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL hold_release got=%b want=0", valid); end
    endtask

    task automatic test_reset_in_hold();
        do_reset();
        in_vec = 4'b0100;
        req    = 4'b0100;
        step();
        step();
        step();
        checks++; if (valid !== 1'b1 || data !== 1'b1) begin errors++; $display("FAIL rhold_setup got valid=%b data=%b want 1/1", valid, data); end
        reset = 1'b1;
        step();
        reset = 1'b0;
        req   = 4'b0000;
        checks++;
        if (grant !== 4'b0000 || valid !== 1'b0 || data !== 1'b0 || {addr1, addr0} !== 2'b00) begin
            errors++;
            $display("FAIL rhold_values got grant=%b valid=%b data=%b addr=%b want 0000/0/0/00", grant, valid, data, {addr1, addr0});
        end
        req = 4'b1111;
        step();
        checks++; if (grant !== 4'b0001) begin errors++; $display("FAIL rhold_first_grant got=%b want=0001", grant); end
        req = 4'b0000;
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_fairness(4'b0101);
        test_fairness(4'b1010);
        test_abort();
        test_hold_stability();
        test_reset_in_hold();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
